// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic                start;
    logic                flush;
    logic [1:0]          op;
    logic [XLEN-1:0]     Op1;
    logic [XLEN-1:0]     Op2;
    logic                busy;
    logic                done;
    logic                div_zero;
    logic                EXE_Zero;
    logic [2*XLEN-1:0]   Result;

    modport master (
        output start, flush, op, Op1, Op2,
        input  busy, done, div_zero, EXE_Zero, Result
    );

    modport slave (
        input  start, flush, op, Op1, Op2,
        output busy, done, div_zero, EXE_Zero, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU: one bit per cycle on operand magnitudes,
// sign fix-up in a final cycle, result packed as {HI,LO} / {remainder,quotient}.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                accept;
    logic [CW-1:0]       cnt_q;
    logic [1:0]          op_q;
    logic [XLEN-1:0]     mag1_q, mag2_q, raw1_q;
    logic                sign_pq_q, sign_r_q;
    logic [2*XLEN-1:0]   acc_q, acc_next;
    logic [2*XLEN-1:0]   result_q, fix_val;
    logic                div_zero_q, zero_q, fix_dz;

    logic                s1, s2;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_sh;
    logic [XLEN+1:0]     trial;
    logic [XLEN-1:0]     rem_new, quo, rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_LOAD;
                accept  = 1'b1;
            end
            S_LOAD: state_d = S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (bus.start) begin
                state_d = S_LOAD;
                accept  = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
            accept  = 1'b0;
        end
    end

    assign bus.busy     = (state_q == S_LOAD) || (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done     = (state_q == S_DONE);
    assign bus.div_zero = div_zero_q;
    assign bus.EXE_Zero = zero_q;
    assign bus.Result   = result_q;

    assign s1 = bus.op[0] & bus.Op1[XLEN-1];
    assign s2 = bus.op[0] & bus.Op2[XLEN-1];

    // Operands are captured on the accepting edge so later bus activity cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            mag1_q    <= '0;
            mag2_q    <= '0;
            raw1_q    <= '0;
            sign_pq_q <= 1'b0;
            sign_r_q  <= 1'b0;
        end else if (accept) begin
            op_q      <= bus.op;
            mag1_q    <= s1 ? -bus.Op1 : bus.Op1;
            mag2_q    <= s2 ? -bus.Op2 : bus.Op2;
            raw1_q    <= bus.Op1;
            sign_pq_q <= s1 ^ s2;
            sign_r_q  <= s1;
        end
    end

    // Remainder is shifted with one extra carry bit so a divisor near 2^XLEN never overflows it.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag1_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        trial    = {1'b0, rem_sh} - {2'b00, mag2_q};
        rem_new  = trial[XLEN+1] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        if (op_q[1]) acc_next = {rem_new, acc_q[XLEN-2:0], ~trial[XLEN+1]};
        else         acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == S_LOAD) begin
            acc_q <= {{XLEN{1'b0}}, (op_q[1] ? mag1_q : mag2_q)};
            cnt_q <= CW'(XLEN-1);
        end else if (state_q == S_CALC) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        quo    = acc_q[XLEN-1:0];
        rem    = acc_q[2*XLEN-1:XLEN];
        fix_dz = op_q[1] && (mag2_q == '0);
        if (!op_q[1])    fix_val = sign_pq_q ? -acc_q : acc_q;
        else if (fix_dz) fix_val = {raw1_q, {XLEN{1'b1}}};
        else             fix_val = {(sign_r_q ? -rem : rem), (sign_pq_q ? -quo : quo)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            div_zero_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (state_q == S_FIX && !bus.flush) begin
            result_q   <= fix_val;
            div_zero_q <= fix_dz;
            zero_q     <= (fix_val == '0);
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized checks of muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [63:0] exp_res, last_res;
    logic        exp_dz;

    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, r;
        longint      sa, sb, q, m;
        logic        dz;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        r  = '0;
        case (o)
            2'b00: r = ua * ub;
            2'b01: r = 64'(sa * sb);
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                    r  = {a, 32'hFFFFFFFF};
                end else if (o == 2'b10) begin
                    r = {a % b, a / b};
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
        endcase
        return {dz, r};
    endfunction

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_done"}, bus.done, 1'b0);
        chk1({tag, "_dz"}, bus.div_zero, 1'b0);
        chk1({tag, "_zero"}, bus.EXE_Zero, 1'b0);
        chk64({tag, "_result"}, bus.Result, 64'd0);
    endtask

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] m;
        bus.start = 1'b1;
        bus.op    = o;
        bus.Op1   = a;
        bus.Op2   = b;
        m         = model(o, a, b);
        exp_dz    = m[64];
        exp_res   = m[63:0];
    endtask

    // Returns at the negedge inside the DONE cycle (or after the cycle budget expires).
    task automatic await(input string tag, input bit noisy);
        int  lat;
        bit  busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            lat = k;
            if (k == 1) bus.start = 1'b0;
            if (k == 2) begin
                bus.op  = 2'($urandom);
                bus.Op1 = $urandom;
                bus.Op2 = $urandom;
            end
            if (noisy && (k == 5 || k == 20)) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom);
                bus.Op1   = $urandom;
                bus.Op2   = $urandom;
            end
            if (noisy && (k == 6 || k == 21)) bus.start = 1'b0;
            if (bus.done) break;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (k == 45) lat = 46;
        end
        chk64({tag, "_latency"}, 64'(lat), 64'd35);
        chk1({tag, "_busy_held"}, busy_ok, 1'b1);
        chk1({tag, "_busy_at_done"}, bus.busy, 1'b0);
        chk64({tag, "_result"}, bus.Result, exp_res);
        chk1({tag, "_div_zero"}, bus.div_zero, exp_dz);
        chk1({tag, "_exe_zero"}, bus.EXE_Zero, exp_res == 64'd0);
        last_res = exp_res;
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        bit          seen_done;

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.Op1   = '0;
        bus.Op2   = '0;
        last_res  = '0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b01, 32'hFFFFFFFE, 32'h00000003);
        await("mult_neg", 1'b0);
        chk64("mult_neg_const", bus.Result, 64'hFFFFFFFF_FFFFFFFA);
        @(negedge clk);

        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        await("multu_max", 1'b0);
        chk64("multu_max_const", bus.Result, 64'hFFFFFFFE_00000001);
        issue(2'b00, 32'd0, 32'd5);
        await("multu_b2b_zero", 1'b0);
        chk1("multu_b2b_zero_const", bus.EXE_Zero, 1'b1);
        @(negedge clk);

        issue(2'b11, 32'hFFFFFFF9, 32'd2);
        await("div_signs", 1'b0);
        chk64("div_signs_const", bus.Result, {32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        await("divu", 1'b0);
        chk64("divu_const", bus.Result, {32'd1, 32'h7FFFFFFC});
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
        await("div_ovf", 1'b0);
        chk64("div_ovf_const", bus.Result, 64'h00000000_80000000);
        issue(2'b10, 32'd1234, 32'd0);
        await("divu_zero", 1'b0);
        chk64("divu_zero_const", bus.Result, {32'd1234, 32'hFFFFFFFF});
        @(negedge clk);

        issue(2'b01, 32'd12345, 32'hFFFFFD5A);
        await("ignore_start", 1'b1);
        @(negedge clk);

        // Flush at T+10 together with a start that must be dropped.
        issue(2'b11, 32'd100, 32'd7);
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.Op1   = $urandom;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk1("flush_busy_drop", bus.busy, 1'b0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        chk1("flush_no_done", seen_done, 1'b0);
        chk64("flush_result_kept", bus.Result, last_res);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            issue(o, a, b);
            await("random", (i % 5) == 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        issue(2'b01, 32'd3, 32'd5);
        await("pre_reset", 1'b0);
        @(negedge clk);
        issue(2'b11, 32'd7777777, 32'hFFFFFFF3);
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        chk1("pre_reset_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b01, 32'd6, 32'd7);
        await("post_reset_mult", 1'b0);
        chk64("post_reset_const", bus.Result, 64'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
